// File: rtl/data_ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous data RAM.
// Round-robin grant with an optional bounded lock for back-to-back bursts.
module data_ram_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [1:0]        req_lock,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        rsp_tag_q, rsp_tag_d;

  logic              grant_vld;
  logic              grant_idx;
  logic              forced;
  logic              rr_idx;

  // Grant selection: lock owner first, forced hand-over at the lock limit, else round-robin
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    forced    = 1'b0;
    rr_idx    = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    if (rst_n) begin
      if (state_q == ST_LOCKED && req_valid[owner_q]) begin
        grant_vld = 1'b1;
        if (lock_cnt_q == CNT_MAX && req_valid[~owner_q]) begin
          grant_idx = ~owner_q;
          forced    = 1'b1;
        end else begin
          grant_idx = owner_q;
        end
      end else if (|req_valid) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx;
      end
    end
  end

  // RAM port and handshake are driven straight from the grant
  always_comb begin
    req_ready = 2'b00;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = grant_idx ? req_addr1 : req_addr0;
    ram_din   = grant_idx ? req_wdata1 : req_wdata0;
    if (grant_vld) begin
      req_ready = grant_idx ? 2'b10 : 2'b01;
      ram_en    = 1'b1;
      ram_we    = req_we[grant_idx];
    end
  end

  // Next-state for lock FSM, round-robin pointer and read response tag
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lock_cnt_d   = lock_cnt_q;
    last_grant_d = last_grant_q;
    rsp_tag_d    = 2'b00;
    if (grant_vld) begin
      last_grant_d = grant_idx;
      if (!req_we[grant_idx]) begin
        rsp_tag_d = grant_idx ? 2'b10 : 2'b01;
      end
      if (forced) begin
        state_d    = ST_OPEN;
        lock_cnt_d = '0;
      end else if (state_q == ST_LOCKED && grant_idx == owner_q) begin
        if (req_lock[grant_idx]) begin
          lock_cnt_d = (lock_cnt_q == CNT_MAX) ? CNT_MAX : lock_cnt_q + CNT_ONE;
        end else begin
          state_d    = ST_OPEN;
          lock_cnt_d = '0;
        end
      end else if (req_lock[grant_idx]) begin
        state_d    = ST_LOCKED;
        owner_d    = grant_idx;
        lock_cnt_d = CNT_ONE;
      end else begin
        state_d    = ST_OPEN;
        lock_cnt_d = '0;
      end
    end else if (state_q == ST_LOCKED && !req_valid[owner_q]) begin
      state_d    = ST_OPEN;
      lock_cnt_d = '0;
    end
  end

  // State registers; reset drops any pending response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OPEN;
      owner_q      <= 1'b0;
      lock_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      rsp_tag_q    <= 2'b00;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lock_cnt_q   <= lock_cnt_d;
      last_grant_q <= last_grant_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign rsp_valid = rsp_tag_q;
  assign rsp_rdata = ram_dout;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a behavioural sync RAM and a response scoreboard.
module tb_data_ram_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid, req_we, req_lock, req_ready, rsp_valid;
  logic [ADDR_W-1:0] req_addr0, req_addr1, ram_addr;
  logic [DATA_W-1:0] req_wdata0, req_wdata1, rsp_rdata, ram_din, ram_dout;
  logic              ram_en, ram_we;

  data_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] pat(input int i);
    return DATA_W'(i) * 32'h9E3779B1;
  endfunction

  // Behavioural synchronous RAM, preloaded with a pattern on reset
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= pat(i);
      ram_dout <= '0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  typedef struct {
    logic [1:0]        tag;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t              sb[$];
  logic [DATA_W-1:0] exp_mem [0:DEPTH-1];
  int                n_checks = 0;
  int                n_fail   = 0;

  task automatic reset_exp_mem();
    for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = pat(i);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check combinational grant/RAM port, then check the response one edge later
  task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                      input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                      input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                      input logic [1:0] exp_rdy, input string tag);
    logic              idx;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    rsp_t              e;
    rsp_t              got;
    req_valid = v; req_we = we; req_lock = lk;
    req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
    #1;
    chk({tag, ".ready"}, 64'(req_ready), 64'(exp_rdy));
    chk({tag, ".ram_en"}, 64'(ram_en), 64'(exp_rdy != 2'b00));
    e.tag = 2'b00; e.data = '0;
    if (exp_rdy != 2'b00) begin
      idx = exp_rdy[1];
      ea  = idx ? a1 : a0;
      ed  = idx ? d1 : d0;
      chk({tag, ".ram_we"}, 64'(ram_we), 64'(we[idx]));
      chk({tag, ".ram_addr"}, 64'(ram_addr), 64'(ea));
      if (we[idx]) begin
        chk({tag, ".ram_din"}, 64'(ram_din), 64'(ed));
        exp_mem[ea] = ed;
      end else begin
        e.tag  = idx ? 2'b10 : 2'b01;
        e.data = exp_mem[ea];
      end
    end else begin
      chk({tag, ".ram_we"}, 64'(ram_we), 64'(0));
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(got.tag));
    if (got.tag != 2'b00) chk({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(got.data));
  endtask

  initial begin
    logic [ADDR_W-1:0] a0, a1;
    logic [1:0]        e;

    reset_exp_mem();
    rst_n = 1'b0;
    req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    #12;
    chk("rst.ready", 64'(req_ready), 64'(0));
    chk("rst.ram_en", 64'(ram_en), 64'(0));
    chk("rst.ram_we", 64'(ram_we), 64'(0));
    chk("rst.rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write then read back
    step(2'b01, 2'b01, 2'b00, 10'h010, 10'h000, 32'hDEADBEEF, '0, 2'b01, "wr010");
    step(2'b01, 2'b00, 2'b00, 10'h010, 10'h000, '0, '0, 2'b01, "rd010");

    // req1 write leaves last_grant=1, then 4 cycles of contention: 0,1,0,1
    step(2'b10, 2'b10, 2'b00, 10'h000, 10'h020, '0, 32'hCAFEF00D, 2'b10, "wr020");
    step(2'b11, 2'b00, 2'b00, 10'h010, 10'h020, '0, '0, 2'b01, "rr1");
    step(2'b11, 2'b00, 2'b00, 10'h030, 10'h020, '0, '0, 2'b10, "rr2");
    step(2'b11, 2'b00, 2'b00, 10'h030, 10'h040, '0, '0, 2'b01, "rr3");
    step(2'b11, 2'b00, 2'b00, 10'h050, 10'h040, '0, '0, 2'b10, "rr4");

    // req1 alone with lock past the limit keeps the grant, then req0 forces a hand-over
    for (int i = 0; i < 10; i++)
      step(2'b10, 2'b00, 2'b10, 10'h000, ADDR_W'(10'h200 + i), '0, '0, 2'b10, "sat");
    step(2'b11, 2'b00, 2'b10, 10'h010, 10'h20A, '0, '0, 2'b01, "forced");

    // req1 locked burst against a waiting req0: 8 grants, one to req0, then a new lock
    a0 = 10'h030; a1 = 10'h20A;
    for (int c = 1; c <= 12; c++) begin
      e = (c == 9) ? 2'b01 : 2'b10;
      step(2'b11, 2'b00, 2'b10, a0, a1, '0, '0, e, "lock");
      if (e == 2'b10) a1 = a1 + ADDR_W'(1);
      else            a0 = 10'h050;
    end
    // Owner drops valid: lock releases and req0 is granted with no idle cycle
    step(2'b01, 2'b00, 2'b00, a0, a1, '0, '0, 2'b01, "ownerdrop");

    // req1 write sets last_grant=1; req0 locks 3 transfers, releases on the 4th, req1 next
    step(2'b10, 2'b10, 2'b00, 10'h000, 10'h060, '0, 32'h0000_0060, 2'b10, "wr060");
    for (int c = 1; c <= 4; c++)
      step(2'b11, 2'b00, (c < 4) ? 2'b01 : 2'b00, ADDR_W'(10'h300 + c), 10'h020, '0, '0,
           2'b01, "rel");
    step(2'b11, 2'b00, 2'b00, 10'h305, 10'h020, '0, '0, 2'b10, "relnext");
    step(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, '0, '0, 2'b00, "idle");

    // Write then read of the same address on consecutive cycles
    step(2'b01, 2'b01, 2'b00, 10'h3FF, 10'h000, 32'h12345678, '0, 2'b01, "wr3ff");
    step(2'b10, 2'b00, 2'b00, 10'h000, 10'h3FF, '0, '0, 2'b10, "rd3ff");

    // Reset while a req1 read response is pending
    req_valid = 2'b10; req_we = 2'b00; req_lock = 2'b00; req_addr1 = 10'h020;
    #1;
    chk("midrst.ready", 64'(req_ready), 64'(2'b10));
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    reset_exp_mem();
    #1;
    chk("midrst.rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midrst.ready_low", 64'(req_ready), 64'(0));
    chk("midrst.ram_en", 64'(ram_en), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("midrst.rsp_hold", 64'(rsp_valid), 64'(0));
    rst_n = 1'b1;
    step(2'b11, 2'b11, 2'b00, 10'h011, 10'h012, 32'h1111_1111, 32'h2222_2222, 2'b01, "postrst1");
    step(2'b10, 2'b10, 2'b00, 10'h000, 10'h012, '0, 32'h2222_2222, 2'b10, "postrst2");
    step(2'b00, 2'b00, 2'b00, 10'h000, 10'h000, '0, '0, 2'b00, "postrst3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
